spi_wave_loader: RTL

//   SPI slave that receives fixed-width command frames and loads waveform samples into per-channel

---
 rtl/spi_wave_loader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_wave_loader.sv
// ---------------------------------------------------------------------------
// spi_wave_loader
//
// SPI mode-0 slave that receives fixed-width {cmd, addr, data} frames and
// turns them into sample-memory writes and per-channel playback settings
// (current channel, last-sample index and run enable). Each completed frame
// is echoed back on MISO during the following frame.
//
// All SPI pins are oversampled in the clk domain through 2-FF synchronisers,
// so clk must run at least 4x faster than SCK.
//
// Ports:
//   clk, rst     system clock (rising edge) and asynchronous active-high reset
//   SCK/MOSI     SPI clock and data in (MSB first, sampled on SCK rise)
//   SSEL         SPI select, active-low
//   MISO         echo of the previous completed frame, 0 while SSEL is high
//   mem_we       1-clk sample-memory write strobe
//   mem_ch       write channel
//   mem_addr     write address
//   mem_wdata    write data
//   ch_len       per-channel last sample index, channel n at [n*ADDR_W +: ADDR_W]
//   run_en       per-channel playback enable
//   rx_valid     1-clk pulse per completed frame
//   frame_err    sticky: SSEL released in the middle of a frame
//   cmd_err      sticky: unknown command or out-of-range channel select
//   frame_cnt    completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module spi_wave_loader #(
    parameter  int CMD_W   = 4,
    parameter  int ADDR_W  = 14,
    parameter  int DATA_W  = 14,
    parameter  int NUM_CH  = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SCK,
    input  logic                     MOSI,
    input  logic                     SSEL,
    output logic                     MISO,
    output logic                     mem_we,
    output logic [CH_W-1:0]          mem_ch,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [NUM_CH*ADDR_W-1:0] ch_len,
    output logic [NUM_CH-1:0]        run_en,
    output logic                     rx_valid,
    output logic                     frame_err,
    output logic                     cmd_err,
    output logic [15:0]              frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_W);

    localparam logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_SEL_CH  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_SET_LEN = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_RUN     = CMD_W'(4);

    // -----------------------------------------------------------------------
    // Input synchronisers and SCK edge detection
    // -----------------------------------------------------------------------
    logic sck_s1_reg, sck_s2_reg, sck_prev_reg;
    logic mosi_s1_reg, mosi_s2_reg;
    logic ssel_s1_reg, ssel_s2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1_reg   <= 1'b0;
            sck_s2_reg   <= 1'b0;
            sck_prev_reg <= 1'b0;
            mosi_s1_reg  <= 1'b0;
            mosi_s2_reg  <= 1'b0;
            // Select idles deasserted so nothing is clocked in until the
            // real pin level has propagated through the synchroniser.
            ssel_s1_reg  <= 1'b1;
            ssel_s2_reg  <= 1'b1;
        end else begin
            sck_s1_reg   <= SCK;
            sck_s2_reg   <= sck_s1_reg;
            sck_prev_reg <= sck_s2_reg;
            mosi_s1_reg  <= MOSI;
            mosi_s2_reg  <= mosi_s1_reg;
            ssel_s1_reg  <= SSEL;
            ssel_s2_reg  <= ssel_s1_reg;
        end
    end

    logic sck_rise, sck_fall;
    assign sck_rise = sck_s2_reg & ~sck_prev_reg;
    assign sck_fall = ~sck_s2_reg & sck_prev_reg;

    // -----------------------------------------------------------------------
    // Receive shifter and bit counter
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [FRAME_W-2:0] rx_shift_reg;   // the last bit comes straight from mosi_s2_reg
    logic               frame_err_reg;
    logic               frame_last;
    logic [FRAME_W-1:0] frame_word;
    logic [CMD_W-1:0]   f_cmd;
    logic [ADDR_W-1:0]  f_addr;
    logic [DATA_W-1:0]  f_data;

    assign frame_last = sck_rise & ~ssel_s2_reg & (bit_cnt_reg == CNT_W'(FRAME_W - 1));
    assign frame_word = {rx_shift_reg, mosi_s2_reg};
    assign f_cmd      = frame_word[FRAME_W-1 -: CMD_W];
    assign f_addr     = frame_word[DATA_W +: ADDR_W];
    assign f_data     = frame_word[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else if (ssel_s2_reg) begin
            // Deselect discards any partial frame; a non-zero count means
            // the master gave up mid-frame.
            bit_cnt_reg <= '0;
            if (bit_cnt_reg != '0) begin
                frame_err_reg <= 1'b1;
            end
        end else if (sck_rise) begin
            rx_shift_reg <= {rx_shift_reg[FRAME_W-3:0], mosi_s2_reg};
            bit_cnt_reg  <= frame_last ? '0 : bit_cnt_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Frame completion: pulse, counter and echo capture
    // -----------------------------------------------------------------------
    logic               rx_valid_reg;
    logic [15:0]        frame_cnt_reg;
    logic [FRAME_W-1:0] echo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            echo_reg      <= '0;
        end else begin
            rx_valid_reg <= frame_last;
            if (frame_last) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                echo_reg      <= frame_word;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Command decode, executed in the same cycle rx_valid is raised
    // -----------------------------------------------------------------------
    logic              mem_we_next;
    logic              len_we_next;
    logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;
    logic [NUM_CH-1:0] run_en_reg, run_en_next;
    logic              cmd_err_reg, cmd_err_next;
    logic              mem_we_reg;
    logic [CH_W-1:0]   mem_ch_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    always_comb begin
        mem_we_next  = 1'b0;
        len_we_next  = 1'b0;
        cur_ch_next  = cur_ch_reg;
        run_en_next  = run_en_reg;
        cmd_err_next = cmd_err_reg;
        if (frame_last) begin
            case (f_cmd)
                CMD_WRITE:   mem_we_next = 1'b1;
                CMD_SEL_CH: begin
                    if (f_data < DATA_W'(NUM_CH)) begin
                        cur_ch_next = f_data[CH_W-1:0];
                    end else begin
                        cmd_err_next = 1'b1;
                    end
                end
                CMD_SET_LEN: len_we_next = 1'b1;
                CMD_RUN:     run_en_next = f_data[NUM_CH-1:0];
                default:     cmd_err_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch_reg    <= '0;
            run_en_reg    <= '0;
            cmd_err_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_ch_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            cur_ch_reg  <= cur_ch_next;
            run_en_reg  <= run_en_next;
            cmd_err_reg <= cmd_err_next;
            mem_we_reg  <= mem_we_next;
            // Write bus holds its last value between strobes.
            if (mem_we_next) begin
                mem_ch_reg    <= cur_ch_reg;
                mem_addr_reg  <= f_addr;
                mem_wdata_reg <= f_data;
            end
        end
    end

    // Per-channel length registers
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_len
            logic [ADDR_W-1:0] len_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    len_reg <= '0;
                end else if (len_we_next && (cur_ch_reg == CH_W'(gi))) begin
                    len_reg <= f_addr;
                end
            end
            assign ch_len[gi*ADDR_W +: ADDR_W] = len_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // MISO echo shifter
    // -----------------------------------------------------------------------
    // Reload has priority whenever the counter sits at 0, so the SCK fall
    // that ends one frame cannot shift away the MSB of the next echo.
    logic [FRAME_W-1:0] tx_shift_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_reg <= '0;
        end else if (!ssel_s2_reg) begin
            if (bit_cnt_reg == '0) begin
                tx_shift_reg <= echo_reg;
            end else if (sck_fall) begin
                tx_shift_reg <= {tx_shift_reg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign MISO      = ssel_s2_reg ? 1'b0 : tx_shift_reg[FRAME_W-1];
    assign mem_we    = mem_we_reg;
    assign mem_ch    = mem_ch_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign run_en    = run_en_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign cmd_err   = cmd_err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
